// File: rtl/cuboid_pkg.sv
// Shared types for the cuboid result collector.
//   WORD_W          - width of one serial result word
//   coll_state_t    - deserializer state (IDLE, GOT_A, GOT_V)
//   cuboid_result_t - one buffered frame {area, volume, perim}
package cuboid_pkg;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      GOT_A,
      GOT_V
   } coll_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] area;
      logic [WORD_W-1:0] volume;
      logic [WORD_W-1:0] perim;
   } cuboid_result_t;
endpackage

// File: rtl/cuboid_res_fifo.sv
// First-word-fall-through result FIFO with registered storage.
//   clk, rst - clock, synchronous active-high reset (pointers/level only)
//   push     - write wr_data; accepted if not full, or full with a pop
//   pop      - advance head; ignored when empty
//   rd_data  - head entry, valid whenever empty is low
//   full, empty, level - occupancy status
module cuboid_res_fifo
   import cuboid_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  cuboid_result_t           wr_data,
   input  logic                     pop,
   output cuboid_result_t           rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   cuboid_result_t mem [DEPTH];
   logic [AW-1:0]  wptr, rptr;
   logic           wr_en, rd_en;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);

   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (rd_en) rptr <= rptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wr_data;
   end
endmodule

// File: rtl/cuboid_collector.sv
// Collects serial A/V/P result words into frames and buffers them.
//   in_data/in_start/in_valid - serial words, A first (with in_start), then V, P
//   out_area/out_volume/out_perim/out_valid/out_ready - head of result FIFO
//   err_frame  - one-cycle pulse on a framing violation
//   drop_cnt   - saturating count of frames lost to a full FIFO
//   fifo_level - current FIFO occupancy
module cuboid_collector
   import cuboid_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WORD_W-1:0]             in_data,
   input  logic                          in_start,
   input  logic                          in_valid,
   output logic [WORD_W-1:0]             out_area,
   output logic [WORD_W-1:0]             out_volume,
   output logic [WORD_W-1:0]             out_perim,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          err_frame,
   output logic [CNT_W-1:0]              drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   coll_state_t    state, state_n;
   logic           err_n, cap_a, cap_v, done;
   logic [WORD_W-1:0] a_q, v_q;
   logic           push_vld;
   cuboid_result_t push_data, head;
   logic           full, empty, pop, drop;

   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      cap_a   = 1'b0;
      cap_v   = 1'b0;
      done    = 1'b0;
      if (in_valid && in_start) begin
         // A start always restarts the frame; it is only an error mid-frame.
         cap_a   = 1'b1;
         state_n = GOT_A;
         err_n   = (state != IDLE);
      end else if (in_valid) begin
         case (state)
            GOT_A: begin
               cap_v   = 1'b1;
               state_n = GOT_V;
            end
            GOT_V: begin
               done    = 1'b1;
               state_n = IDLE;
            end
            default: err_n = 1'b1;
         endcase
      end else if (state != IDLE) begin
         err_n   = 1'b1;
         state_n = IDLE;
      end
   end

   assign pop  = out_valid && out_ready;
   assign drop = push_vld && full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         err_frame <= 1'b0;
         push_vld  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_n;
         err_frame <= err_n;
         push_vld  <= done;
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // Payload registers; a stale value is harmless because push_vld gates use.
   always_ff @(posedge clk) begin
      if (cap_a) a_q <= in_data;
      if (cap_v) v_q <= in_data;
      if (done) push_data <= '{area: a_q, volume: v_q, perim: in_data};
   end

   cuboid_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_vld),
      .wr_data (push_data),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   assign out_valid  = !empty;
   assign out_area   = head.area;
   assign out_volume = head.volume;
   assign out_perim  = head.perim;
endmodule

// File: tb/tb_cuboid_collector.sv
module tb_cuboid_collector;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic        clk = 1'b0;
   logic        rst, in_start, in_valid, out_ready;
   logic [31:0] in_data;
   logic [31:0] out_area, out_volume, out_perim;
   logic        out_valid, err_frame;
   logic [CNT_W-1:0]          drop_cnt;
   logic [$clog2(DEPTH):0]    fifo_level;

   cuboid_collector #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_start(in_start),
      .in_valid(in_valid), .out_area(out_area), .out_volume(out_volume),
      .out_perim(out_perim), .out_valid(out_valid), .out_ready(out_ready),
      .err_frame(err_frame), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // Reference model: queue of delivered frames, list of words of the frame in progress.
   logic [95:0] mq[$];
   logic [31:0] part[$];
   logic [95:0] pend_data;
   bit          pend_vld = 0;
   int          m_drop = 0;
   bit          m_err = 0;

   int n_cmp = 0, n_bad = 0;
   int err_cnt = 0, ov_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  size_pre;
      bit  pop, new_pend;
      if (rst) begin
         mq.delete(); part.delete();
         pend_vld = 0; m_drop = 0; m_err = 0;
      end else begin
         size_pre = mq.size();
         pop = (size_pre > 0) && out_ready;
         if (pop) void'(mq.pop_front());
         if (pend_vld) begin
            if (size_pre == DEPTH && !pop) begin
               if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end else mq.push_back(pend_data);
         end
         m_err = 0; new_pend = 0;
         if (in_valid && in_start) begin
            if (part.size() > 0) m_err = 1;
            part.delete();
            part.push_back(in_data);
         end else if (in_valid) begin
            if (part.size() == 0) m_err = 1;
            else begin
               part.push_back(in_data);
               if (part.size() == 3) begin
                  pend_data = {part[0], part[1], part[2]};
                  new_pend = 1;
                  part.delete();
               end
            end
         end else if (part.size() > 0) begin
            m_err = 1;
            part.delete();
         end
         pend_vld = new_pend;
      end
   endtask

   task automatic compare_all();
      logic [95:0] h;
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("err_frame", 32'(err_frame), 32'(m_err));
      if (mq.size() > 0) begin
         h = mq[0];
         chk("out_area", out_area, h[95:64]);
         chk("out_volume", out_volume, h[63:32]);
         chk("out_perim", out_perim, h[31:0]);
      end
      err_cnt += int'(err_frame);
      ov_cnt  += int'(out_valid);
   endtask

   task automatic cyc(input logic v, input logic s, input logic [31:0] d,
                      input logic r, input logic rs);
      in_valid = v; in_start = s; in_data = d; out_ready = r; rst = rs;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic frame(input logic [31:0] a, input logic [31:0] v,
                        input logic [31:0] p, input logic r);
      cyc(1, 1, a, r, 0);
      cyc(1, 0, v, r, 0);
      cyc(1, 0, p, r, 0);
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) cyc(0, $urandom_range(0, 1), $urandom, r, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 32'hdead, 1, 1);
      cyc(1, 1, 32'hbeef, 0, 1);
      err_cnt = 0; ov_cnt = 0;
   endtask

   initial begin
      int kind, bias;
      in_valid = 0; in_start = 0; in_data = '0; out_ready = 0; rst = 1;
      do_reset();

      // Single frame, ready always high.
      frame(52, 24, 36, 1);
      idle(5, 1);
      chk("r036_valid_cycles", 32'(ov_cnt), 32'd1);

      // Five frames into a depth-4 FIFO with the consumer stalled.
      do_reset();
      for (int i = 0; i < 5; i++) frame(100 + i, 200 + i, 300 + i, 0);
      idle(1, 0);
      chk("r037_level", 32'(fifo_level), 32'd4);
      chk("r037_drop", 32'(drop_cnt), 32'd1);
      idle(8, 1);

      // Full FIFO, push coincides with a pop.
      do_reset();
      for (int i = 0; i < 4; i++) frame(10 + i, 20 + i, 30 + i, 0);
      idle(1, 0);
      frame(77, 88, 99, 0);
      cyc(0, 0, 0, 1, 0);
      chk("r040_level", 32'(fifo_level), 32'd4);
      chk("r040_drop", 32'(drop_cnt), 32'd0);
      idle(8, 1);

      // Restart while in GOT_V.
      do_reset();
      cyc(1, 1, 1, 1, 0); cyc(1, 0, 2, 1, 0);
      frame(11, 12, 13, 1);
      idle(4, 1);
      chk("r038_err_pulses", 32'(err_cnt), 32'd1);
      chk("r038_delivered", 32'(ov_cnt), 32'd1);

      // Gap after A, then a good frame.
      do_reset();
      cyc(1, 1, 9, 1, 0); cyc(0, 0, 0, 1, 0);
      frame(6, 1, 4, 1);
      idle(4, 1);
      chk("r039_err_pulses", 32'(err_cnt), 32'd1);
      chk("r039_delivered", 32'(ov_cnt), 32'd1);

      // Reset in GOT_A with two entries queued.
      do_reset();
      frame(1, 2, 3, 0); frame(4, 5, 6, 0);
      idle(2, 0);
      cyc(1, 1, 7, 0, 0);
      err_cnt = 0;
      cyc(1, 0, 8, 0, 1);
      chk("r041_valid", 32'(out_valid), 32'd0);
      chk("r041_level", 32'(fifo_level), 32'd0);
      frame(21, 22, 23, 1);
      idle(4, 1);
      chk("r041_err_pulses", 32'(err_cnt), 32'd0);

      // Drop counter saturation.
      do_reset();
      for (int i = 0; i < 14; i++) frame($urandom, $urandom, $urandom, 0);
      idle(1, 0);
      chk("sat_drop", 32'(drop_cnt), 32'((1 << CNT_W) - 1));
      idle(6, 1);

      // Randomized traffic with framing errors, stalls and occasional reset.
      bias = 2;
      for (int it = 0; it < 400; it++) begin
         kind = $urandom_range(0, 15);
         if (it % 40 == 0) bias = $urandom_range(0, 3);
         if (kind < 9) begin
            cyc(1, 1, $urandom, $urandom_range(0, 3) < bias, 0);
            cyc(1, 0, $urandom, $urandom_range(0, 3) < bias, 0);
            cyc(1, 0, $urandom, $urandom_range(0, 3) < bias, 0);
         end else if (kind < 11) begin
            idle($urandom_range(1, 3), $urandom_range(0, 3) < bias);
         end else if (kind < 13) begin
            cyc(1, 1, $urandom, $urandom_range(0, 1), 0);
            if ($urandom_range(0, 1)) cyc(1, 0, $urandom, $urandom_range(0, 1), 0);
            cyc(0, 0, $urandom, $urandom_range(0, 1), 0);
         end else if (kind < 15) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                $urandom_range(0, 1), 0);
         end else begin
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom, 1, 1);
         end
      end
      idle(10, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
